// File: rtl/cls_spi_frame_sender_if.sv
// Table-fetch and SPI pin bundle between the frame sender and its neighbours.
// The sender is the SPI master; the slave side supplies table bytes and gating.
interface cls_spi_frame_sender_if;
   logic [7:0] data_out;
   logic       buffer_ready;
   logic [5:0] sel;
   logic       ss;
   logic       sclk;
   logic       mosi;
   logic       busy;
   logic       frame_done;

   modport master (
      input  data_out, buffer_ready,
      output sel, ss, sclk, mosi, busy, frame_done
   );

   modport slave (
      output data_out, buffer_ready,
      input  sel, ss, sclk, mosi, busy, frame_done
   );
endinterface

// File: rtl/cls_spi_frame_sender.sv
// Walks the PmodCLS table from index 0 and sends each byte as one SS-framed
// SPI mode-0 transfer, once per refresh period while the line buffer is idle.
module cls_spi_frame_sender #(
   parameter int CLK_DIV         = 50,
   parameter int SS_SETUP_CYCLES = 100,
   parameter int BYTE_GAP_CYCLES = 4000,
   parameter int REFRESH_CYCLES  = 10_000_000,
   parameter int LAST_IDX        = 45
) (
   input logic                    clk,
   input logic                    rst_n,
   cls_spi_frame_sender_if.master bus
);

   localparam int M1   = (2*CLK_DIV > SS_SETUP_CYCLES) ?
                         2*CLK_DIV : SS_SETUP_CYCLES;
   localparam int CMAX = (M1 > BYTE_GAP_CYCLES) ? M1 : BYTE_GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int RW   = $clog2(REFRESH_CYCLES + 1);

   localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] PHASE_LAST = CW'(2*CLK_DIV - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP_CYCLES - 1);
   localparam logic [RW-1:0] R_LAST     = RW'(REFRESH_CYCLES - 1);
   localparam logic [5:0]    SEL_LAST   = 6'(LAST_IDX);

   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, SETUP, SHIFT, HOLD, GAP, DONE
   } state_t;

   state_t        state, nxt;
   logic [CW-1:0] cnt;
   logic [RW-1:0] rcnt;
   logic [2:0]    bitn;
   logic [6:0]    shreg;
   logic [5:0]    sel;
   logic          ss, sclk, mosi, busy, pending;
   logic          launch;

   assign launch = pending && !bus.buffer_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  if (launch) nxt = FETCH;
         FETCH: nxt = LOAD;
         LOAD:  nxt = (bus.data_out == 8'h00) ? DONE : SETUP;
         SETUP: if (cnt == SETUP_LAST) nxt = SHIFT;
         SHIFT: if (cnt == PHASE_LAST && bitn == 3'd7) nxt = HOLD;
         HOLD:  if (cnt == SETUP_LAST) nxt = GAP;
         GAP:   if (cnt == GAP_LAST)
                   nxt = (sel == SEL_LAST) ? DONE : FETCH;
         DONE:  nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.frame_done = (state == DONE);
      bus.sel        = sel;
      bus.ss         = ss;
      bus.sclk       = sclk;
      bus.mosi       = mosi;
      bus.busy       = busy;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         rcnt    <= '0;
         bitn    <= '0;
         shreg   <= '0;
         sel     <= '0;
         ss      <= 1'b1;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         busy    <= 1'b0;
         pending <= 1'b1;
      end else begin
         // one shared phase counter, restarted on every state change
         if (state == IDLE || state != nxt ||
             (state == SHIFT && cnt == PHASE_LAST))
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);

         unique case (state)
            IDLE: if (launch) begin
               pending <= 1'b0;
               sel     <= '0;
               busy    <= 1'b1;
            end
            LOAD: if (bus.data_out != 8'h00) begin
               shreg <= bus.data_out[6:0];
               mosi  <= bus.data_out[7];
               ss    <= 1'b0;
               bitn  <= '0;
            end
            SHIFT: begin
               if (cnt == HALF_LAST) sclk <= 1'b1;
               if (cnt == PHASE_LAST) begin
                  sclk <= 1'b0;
                  if (bitn != 3'd7) begin
                     mosi  <= shreg[6];
                     shreg <= {shreg[5:0], 1'b0};
                     bitn  <= bitn + 3'd1;
                  end
               end
            end
            HOLD: if (cnt == SETUP_LAST) ss <= 1'b1;
            GAP: if (cnt == GAP_LAST && sel != SEL_LAST)
               sel <= sel + 6'd1;
            DONE: begin
               busy <= 1'b0;
               sel  <= '0;
            end
            default: ;
         endcase

         // a wrap outranks a same-cycle launch so no request is lost
         if (rcnt == R_LAST) begin
            rcnt    <= '0;
            pending <= 1'b1;
         end else begin
            rcnt <= rcnt + RW'(1);
         end
      end
   end

endmodule

// File: tb/tb_cls_spi_frame_sender.sv
// Randomised table bench for cls_spi_frame_sender; an SPI monitor decodes
// bytes and the expected frame is the table up to its first null byte.
module tb_cls_spi_frame_sender;
   localparam int CD = 2;
   localparam int SU = 3;
   localparam int GP = 5;
   localparam int RF = 2000;
   localparam int LAST = 45;
   localparam int SS_LOW = SU + 16*CD + SU;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cls_spi_frame_sender_if bus();
   logic [7:0] tbl [0:63];
   assign bus.data_out = tbl[bus.sel];

   cls_spi_frame_sender #(
      .CLK_DIV(CD), .SS_SETUP_CYCLES(SU), .BYTE_GAP_CYCLES(GP),
      .REFRESH_CYCLES(RF), .LAST_IDX(LAST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.master)
   );

   int checks = 0;
   int passes = 0;

   logic [7:0] byte_q [$];
   int bits_q [$];
   int len_q [$];
   int cur_bits, cur_len, rises, fd_cnt, fd_hi, viol, mosi_chg, cyc;
   logic [7:0] cur_sh;
   logic prev_ss, prev_sclk, prev_mosi, prev_fd;
   logic [7:0] exp_q [$];

   initial begin
      viol = 0; mosi_chg = 0; rises = 0; fd_cnt = 0; fd_hi = 0;
      cur_bits = 0; cur_len = 0; cur_sh = 0;
      prev_ss = 1; prev_sclk = 0; prev_mosi = 0; prev_fd = 0;
   end

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ss = 1; prev_sclk = 0; prev_mosi = 0; prev_fd = 0;
         cur_bits = 0; cur_len = 0;
      end else begin
         if (bus.ss && bus.sclk) viol++;
         if (bus.mosi !== prev_mosi) begin
            mosi_chg++;
            if (bus.sclk) viol++;
         end
         if (prev_ss && !bus.ss) begin
            cur_bits = 0; cur_len = 0; cur_sh = 0;
         end
         if (!bus.ss) cur_len++;
         if (!prev_sclk && bus.sclk) begin
            rises++;
            if (!bus.ss) begin
               cur_sh = {cur_sh[6:0], bus.mosi};
               cur_bits++;
            end
         end
         if (!prev_ss && bus.ss) begin
            byte_q.push_back(cur_sh);
            bits_q.push_back(cur_bits);
            len_q.push_back(cur_len);
         end
         if (bus.frame_done) fd_hi++;
         if (bus.frame_done && !prev_fd) fd_cnt++;
         prev_ss = bus.ss; prev_sclk = bus.sclk;
         prev_mosi = bus.mosi; prev_fd = bus.frame_done;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clr_mon();
      byte_q.delete(); bits_q.delete(); len_q.delete();
      rises = 0; fd_cnt = 0; fd_hi = 0;
   endtask

   // The frame is every table byte from index 0 until the first null.
   task automatic build_expected();
      exp_q.delete();
      for (int i = 0; i <= LAST; i++) begin
         if (tbl[i] == 8'h00) break;
         exp_q.push_back(tbl[i]);
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      bus.buffer_ready = 0;
      repeat (3) step();
      checks++;
      if (bus.ss !== 1'b1) $display("FAIL rst_ss: got %b want 1", bus.ss);
      else passes++;
      checks++;
      if (bus.sclk !== 1'b0) $display("FAIL rst_sclk: got %b want 0", bus.sclk);
      else passes++;
      checks++;
      if (bus.mosi !== 1'b0) $display("FAIL rst_mosi: got %b want 0", bus.mosi);
      else passes++;
      checks++;
      if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy);
      else passes++;
      checks++;
      if (bus.frame_done !== 1'b0)
         $display("FAIL rst_fd: got %b want 0", bus.frame_done);
      else passes++;
      checks++;
      if (bus.sel !== 6'd0) $display("FAIL rst_sel: got %0d want 0", bus.sel);
      else passes++;
      clr_mon();
      rst_n = 1;
      for (int i = 0; i < 2 && !bus.busy; i++) step();
      checks++;
      if (bus.busy !== 1'b1)
         $display("FAIL launch_after_reset: busy got %b want 1", bus.busy);
      else passes++;
   endtask

   task automatic test_first_byte();
      for (int i = 0; i < 200 && byte_q.size() < 1; i++) step();
      checks++;
      if (byte_q.size() < 1) begin
         $display("FAIL first_byte_timeout: got 0 bytes want 1");
      end else begin
         passes++;
         checks++;
         if (byte_q[0] !== 8'h1B)
            $display("FAIL first_byte: got %h want 1b", byte_q[0]);
         else passes++;
         checks++;
         if (bits_q[0] != 8)
            $display("FAIL first_bits: got %0d want 8", bits_q[0]);
         else passes++;
         checks++;
         if (len_q[0] != SS_LOW)
            $display("FAIL ss_low_len: got %0d want %0d", len_q[0], SS_LOW);
         else passes++;
      end
   endtask

   task automatic test_full_frame();
      int bad;
      bus.buffer_ready = 1;
      for (int i = 0; i < 3000 && fd_cnt < 1; i++) step();
      repeat (5) step();
      build_expected();
      checks++;
      if (byte_q.size() != exp_q.size())
         $display("FAIL full_count: got %0d want %0d", byte_q.size(), exp_q.size());
      else passes++;
      for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
         checks++;
         if (byte_q[i] !== exp_q[i])
            $display("FAIL full_byte%0d: got %h want %h", i, byte_q[i], exp_q[i]);
         else passes++;
      end
      bad = 0;
      foreach (bits_q[i]) if (bits_q[i] != 8 || len_q[i] != SS_LOW) bad++;
      checks++;
      if (bad != 0) $display("FAIL full_framing: got %0d bad bytes want 0", bad);
      else passes++;
      checks++;
      if (fd_cnt != 1 || fd_hi != 1)
         $display("FAIL full_done: got %0d pulses %0d cycles want 1 1", fd_cnt, fd_hi);
      else passes++;
      checks++;
      if (bus.sel !== 6'd0 || bus.busy !== 1'b0)
         $display("FAIL full_after: got sel %0d busy %b want 0 0", bus.sel, bus.busy);
      else passes++;
   endtask

   task automatic test_early_null();
      tbl[10] = 8'h00;
      clr_mon();
      bus.buffer_ready = 0;
      for (int i = 0; i < 2 && !bus.busy; i++) step();
      bus.buffer_ready = 1;
      for (int i = 0; i < 1000 && fd_cnt < 1; i++) step();
      repeat (10) step();
      build_expected();
      checks++;
      if (byte_q.size() != 10 || exp_q.size() != 10)
         $display("FAIL null_count: got %0d want 10", byte_q.size());
      else passes++;
      for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
         checks++;
         if (byte_q[i] !== exp_q[i])
            $display("FAIL null_byte%0d: got %h want %h", i, byte_q[i], exp_q[i]);
         else passes++;
      end
      checks++;
      if (rises != 80) $display("FAIL null_sclk: got %0d rises want 80", rises);
      else passes++;
      checks++;
      if (fd_cnt != 1) $display("FAIL null_done: got %0d want 1", fd_cnt);
      else passes++;
      tbl[10] = 8'($urandom_range(1, 255));
   endtask

   task automatic test_buffer_gate();
      int seen;
      tbl[5] = 8'h00;
      clr_mon();
      seen = 0;
      for (int i = 0; i < 4200; i++) begin
         step();
         if (bus.busy) seen++;
      end
      checks++;
      if (seen != 0 || byte_q.size() != 0)
         $display("FAIL gate_blocked: got %0d busy cycles want 0", seen);
      else passes++;
      for (int i = 0; i < 2100 && (cyc % RF) != 500; i++) step();
      bus.buffer_ready = 0;
      for (int i = 0; i < 2 && !bus.busy; i++) step();
      checks++;
      if (bus.busy !== 1'b1)
         $display("FAIL gate_launch: busy got %b want 1", bus.busy);
      else passes++;
      for (int i = 0; i < 1000 && fd_cnt < 1; i++) step();
      checks++;
      if (fd_cnt != 1 || byte_q.size() != 5)
         $display("FAIL gate_frame: got %0d done %0d bytes want 1 5", fd_cnt, byte_q.size());
      else passes++;
      for (int i = 0; i < 2100 && (cyc % RF) != 1900; i++) step();
      checks++;
      if (fd_cnt != 1 || bus.busy !== 1'b0)
         $display("FAIL gate_no_queue: got %0d done busy %b want 1 0", fd_cnt, bus.busy);
      else passes++;
      for (int i = 0; i < 200 && (cyc % RF) != 20; i++) step();
      checks++;
      if (bus.busy !== 1'b1)
         $display("FAIL gate_next_wrap: busy got %b want 1", bus.busy);
      else passes++;
      bus.buffer_ready = 1;
      for (int i = 0; i < 1000 && fd_cnt < 2; i++) step();
      tbl[5] = 8'($urandom_range(1, 255));
   endtask

   task automatic test_reset_mid();
      rst_n = 0;
      repeat (2) step();
      clr_mon();
      bus.buffer_ready = 0;
      rst_n = 1;
      for (int i = 0; i < 400 && !(byte_q.size() == 3 && cur_bits == 4 && bus.sclk); i++)
         step();
      checks++;
      if (!(byte_q.size() == 3 && cur_bits == 4 && bus.ss === 1'b0))
         $display("FAIL mid_reach: got %0d bytes %0d bits want 3 4", byte_q.size(), cur_bits);
      else passes++;
      rst_n = 0;
      #1;
      checks++;
      if (bus.ss !== 1'b1 || bus.sclk !== 1'b0)
         $display("FAIL mid_async: got ss %b sclk %b want 1 0", bus.ss, bus.sclk);
      else passes++;
      repeat (2) step();
      clr_mon();
      rst_n = 1;
      for (int i = 0; i < 200 && byte_q.size() < 1; i++) step();
      checks++;
      if (byte_q.size() < 1 || byte_q[0] !== 8'h1B)
         $display("FAIL mid_restart: got %0d bytes want first 1b", byte_q.size());
      else passes++;
      bus.buffer_ready = 1;
      for (int i = 0; i < 3000 && fd_cnt < 1; i++) step();
   endtask

   task automatic test_spi_rules();
      checks++;
      if (viol != 0) $display("FAIL spi_rules: got %0d violations want 0", viol);
      else passes++;
      checks++;
      if (mosi_chg == 0) $display("FAIL mosi_activity: got 0 changes want >0");
      else passes++;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) tbl[i] = 8'h00;
      for (int i = 1; i < LAST; i++) tbl[i] = 8'($urandom_range(1, 255));
      tbl[0] = 8'h1B;
      bus.buffer_ready = 0;
      test_reset();
      test_first_byte();
      test_full_frame();
      test_early_null();
      test_buffer_gate();
      test_reset_mid();
      test_spi_rules();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
